// File: rtl/coeff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : coeff_loader_pkg
// Description : Shared types and constants for the FIR coefficient loader:
//               loader state encoding, default tap count, axis codes.
// Revision    : 1.0 - initial release
// ============================================================================
package coeff_loader_pkg;

    localparam int NUM_TAPS_DEFAULT = 16;
    localparam int COEFF_W          = 16;

    // Axis code carried by a bank-load command; NONE marks an invalid target.
    localparam logic [1:0] AXIS_NONE = 2'd0;
    localparam logic [1:0] AXIS_X    = 2'd1;
    localparam logic [1:0] AXIS_Y    = 2'd2;
    localparam logic [1:0] AXIS_Z    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT   = 3'd1,
        S_WAIT_IDLE = 3'd2,
        S_COMMIT    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter. A lone request is always granted;
//               on a tie the requester holding priority wins. Priority passes
//               to the other requester whenever a grant is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Requester that wins a tie; requester 0 after reset.
    logic prio;

    // Grant selection: sole requester wins, ties go to the priority holder.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant_id = prio;
                grant    = prio ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // Hand priority to the other requester once a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : fir_coeff_loader
// Description : Collects a bank of NUM_TAPS coefficients from one of two
//               requesters into a shadow buffer, then writes them to the
//               signal path only while it reports idle.
//               Optional macro COEFF_CHECKSUM_EN: one extra word per load
//               carrying the 16-bit wrap-around sum of the coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                r0_cmd_valid,
    output logic                r0_cmd_ready,
    input  logic [1:0]          r0_axis,
    input  logic [1:0]          r0_bank,
    input  logic                r0_data_valid,
    output logic                r0_data_ready,
    input  logic [COEFF_W-1:0]  r0_data,
    input  logic                r1_cmd_valid,
    output logic                r1_cmd_ready,
    input  logic [1:0]          r1_axis,
    input  logic [1:0]          r1_bank,
    input  logic                r1_data_valid,
    output logic                r1_data_ready,
    input  logic [COEFF_W-1:0]  r1_data,
    input  logic                available,
    output logic                update_en,
    output logic [1:0]          update_axis,
    output logic [1:0]          update_bank,
    output logic [3:0]          update_index,
    output logic [COEFF_W-1:0]  update_value,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic                error
);

    localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CW = $clog2(NUM_TAPS + 1);
    localparam logic [CW-1:0] TAPS_CW  = CW'(NUM_TAPS);
    localparam logic [IW-1:0] LAST_TAP = IW'(NUM_TAPS - 1);
`ifdef COEFF_CHECKSUM_EN
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_TAPS);
`else
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_TAPS - 1);
`endif

    state_t               state, state_nxt;
    logic [1:0]           lat_axis, lat_bank;
    logic                 lat_id;
    logic [CW-1:0]        count;
    logic [IW-1:0]        tap;
    logic                 err_flag;
    logic [COEFF_W-1:0]   shadow [NUM_TAPS];

    logic [1:0]           arb_req, arb_grant;
    logic                 arb_id;
    logic                 cmd_hs, collecting, word_valid, data_hs;
    logic                 last_word, load_bad, commit_en;
    logic [COEFF_W-1:0]   word;

    // Commands are only arbitrated while idle.
    assign arb_req = (state == S_IDLE) ? {r1_cmd_valid, r0_cmd_valid} : 2'b00;

    rr_arbiter_2 u_arb (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .req      (arb_req),
        .accept   (cmd_hs),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // A grant is only issued to a valid requester, so any grant is a handshake.
    assign cmd_hs       = |arb_grant;
    assign r0_cmd_ready = arb_grant[0];
    assign r1_cmd_ready = arb_grant[1];

    // Word stream comes only from the requester whose command was accepted.
    assign collecting    = (state == S_COLLECT);
    assign r0_data_ready = collecting & ~lat_id;
    assign r1_data_ready = collecting &  lat_id;
    assign word_valid    = lat_id ? r1_data_valid : r0_data_valid;
    assign word          = lat_id ? r1_data : r0_data;
    assign data_hs       = collecting & word_valid;
    assign last_word     = data_hs && (count == LAST_WORD);
    assign commit_en     = (state == S_COMMIT) && available;

`ifdef COEFF_CHECKSUM_EN
    logic [COEFF_W-1:0] csum;

    // Running sum of the coefficient words of the current load.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (cmd_hs) begin
            csum <= '0;
        end else if (data_hs && (count < TAPS_CW)) begin
            csum <= csum + word;
        end
    end

    assign load_bad = (lat_axis == AXIS_NONE) || (word != csum);
`else
    assign load_bad = (lat_axis == AXIS_NONE);
`endif

    // State register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (cmd_hs) state_nxt = S_COLLECT;
            S_COLLECT:   if (last_word) state_nxt = load_bad ? S_DONE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (available) state_nxt = S_COMMIT;
            S_COMMIT:    if (commit_en && (tap == LAST_TAP)) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Command latch, word counter, commit index and load verdict.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_axis <= '0;
            lat_bank <= '0;
            lat_id   <= 1'b0;
            count    <= '0;
            tap      <= '0;
            err_flag <= 1'b0;
        end else begin
            if (cmd_hs) begin
                lat_axis <= arb_id ? r1_axis : r0_axis;
                lat_bank <= arb_id ? r1_bank : r0_bank;
                lat_id   <= arb_id;
                count    <= '0;
                tap      <= '0;
                err_flag <= 1'b0;
            end
            if (data_hs) begin
                count <= count + CW'(1);
            end
            if (last_word) begin
                err_flag <= load_bad;
            end
            if (commit_en) begin
                tap <= (tap == LAST_TAP) ? '0 : tap + IW'(1);
            end
        end
    end

    // Shadow buffer; contents survive reset and are overwritten by each load.
    always_ff @(posedge sys_clk) begin
        if (data_hs && (count < TAPS_CW)) begin
            shadow[count[IW-1:0]] <= word;
        end
    end

    // Signal-path write port is zero whenever no write is issued.
    assign update_en    = commit_en;
    assign update_axis  = commit_en ? lat_axis : 2'd0;
    assign update_bank  = commit_en ? lat_bank : 2'd0;
    assign update_index = commit_en ? 4'(tap) : 4'd0;
    assign update_value = commit_en ? shadow[tap] : '0;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign done_id = done & lat_id;
    assign error   = done & err_flag;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_coeff_loader
// Description : Directed self-checking bench for fir_coeff_loader: a table of
//               bank loads plus arbitration and mid-commit reset sequences.
//               Honours COEFF_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_loader;
    import coeff_loader_pkg::*;

    localparam int NUM_TAPS = NUM_TAPS_DEFAULT;
`ifdef COEFF_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NW = NUM_TAPS + (CSUM ? 1 : 0);

    logic        sys_clk, reset_n;
    logic        r0_cmd_valid, r0_cmd_ready, r0_data_valid, r0_data_ready;
    logic [1:0]  r0_axis, r0_bank;
    logic [15:0] r0_data;
    logic        r1_cmd_valid, r1_cmd_ready, r1_data_valid, r1_data_ready;
    logic [1:0]  r1_axis, r1_bank;
    logic [15:0] r1_data;
    logic        available, update_en, busy, done, done_id, error;
    logic [1:0]  update_axis, update_bank;
    logic [3:0]  update_index;
    logic [15:0] update_value;

    int total = 0;
    int bad   = 0;

    fir_coeff_loader #(.NUM_TAPS(NUM_TAPS)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready),
        .r0_axis(r0_axis), .r0_bank(r0_bank),
        .r0_data_valid(r0_data_valid), .r0_data_ready(r0_data_ready), .r0_data(r0_data),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready),
        .r1_axis(r1_axis), .r1_bank(r1_bank),
        .r1_data_valid(r1_data_valid), .r1_data_ready(r1_data_ready), .r1_data(r1_data),
        .available(available),
        .update_en(update_en), .update_axis(update_axis), .update_bank(update_bank),
        .update_index(update_index), .update_value(update_value),
        .busy(busy), .done(done), .done_id(done_id), .error(error)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          req;
        bit          other_valid;
        logic [1:0]  axis;
        logic [1:0]  bank;
        logic [15:0] base;
        logic [15:0] step;
        int          stall_at;
        int          stall_len;
        bit          bad_sum;
        int          abort_at;
        bit          chk_lat;
    } load_vec_t;

    function automatic load_vec_t mk(input int req, input bit oth,
                                     input logic [1:0] axis, input logic [1:0] bank,
                                     input logic [15:0] base, input logic [15:0] step,
                                     input int stall_at, input int stall_len,
                                     input bit bad_sum, input int abort_at,
                                     input bit chk_lat);
        load_vec_t v;
        v.req = req;           v.other_valid = oth;
        v.axis = axis;         v.bank = bank;
        v.base = base;         v.step = step;
        v.stall_at = stall_at; v.stall_len = stall_len;
        v.bad_sum = bad_sum;   v.abort_at = abort_at;
        v.chk_lat = chk_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one bank load and follow it to done (or to a planted reset).
    task automatic run_load(input load_vec_t v);
        logic [15:0] words [NW];
        logic [15:0] sum;
        bit          exp_err, seen_done, stalled;
        int          lat, writes, exp_i, stall_cnt, gaps, upd_in_collect, zero_bad, exp_gaps;
        sum = '0;
        for (int w = 0; w < NUM_TAPS; w++) begin
            words[w] = v.base + v.step * 16'(w);
            sum      = sum + words[w];
        end
`ifdef COEFF_CHECKSUM_EN
        words[NW-1] = v.bad_sum ? sum + 16'd1 : sum;
`endif
        exp_err  = (v.axis == AXIS_NONE) || (CSUM && v.bad_sum);
        exp_gaps = (!exp_err && v.stall_at > 0 && v.stall_at < NUM_TAPS) ? v.stall_len : 0;
        lat = 0; writes = 0; exp_i = 0; stall_cnt = 0; gaps = 0;
        upd_in_collect = 0; zero_bad = 0; seen_done = 1'b0;

        // command phase
        @(negedge sys_clk);
        if (v.req == 0) begin
            r0_cmd_valid = 1'b1; r0_axis = v.axis;  r0_bank = v.bank;
            r1_cmd_valid = v.other_valid; r1_axis = ~v.axis; r1_bank = ~v.bank;
        end else begin
            r1_cmd_valid = 1'b1; r1_axis = v.axis;  r1_bank = v.bank;
            r0_cmd_valid = v.other_valid; r0_axis = ~v.axis; r0_bank = ~v.bank;
        end
        #1;
        check("cmd_ready_granted", 32'(v.req == 0 ? r0_cmd_ready : r1_cmd_ready), 32'd1);
        check("cmd_ready_other",   32'(v.req == 0 ? r1_cmd_ready : r0_cmd_ready), 32'd0);
        @(posedge sys_clk);

        // coefficient stream; the other requester offers junk that must be ignored
        for (int w = 0; w < NW; w++) begin
            @(negedge sys_clk);
            lat++;
            r0_cmd_valid = 1'b0; r1_cmd_valid = 1'b0;
            r0_data_valid = 1'b1; r1_data_valid = 1'b1;
            r0_data = (v.req == 0) ? words[w] : 16'hDEAD;
            r1_data = (v.req == 1) ? words[w] : 16'hDEAD;
            #1;
            if (w == 0) begin
                check("data_ready_granted", 32'(v.req == 0 ? r0_data_ready : r1_data_ready), 32'd1);
                check("data_ready_other",   32'(v.req == 0 ? r1_data_ready : r0_data_ready), 32'd0);
                check("busy_collect", 32'(busy), 32'd1);
            end
            if (update_en) upd_in_collect++;
        end

        // commit phase with optional availability stall
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge sys_clk);
            lat++;
            r0_data_valid = 1'b0; r1_data_valid = 1'b0;
            stalled   = (exp_i == v.stall_at) && (stall_cnt < v.stall_len);
            available = !stalled;
            #1;
            if (stalled) stall_cnt++;
            if (update_en) begin
                check("upd_index", 32'(update_index), 32'(exp_i));
                if (exp_i < NUM_TAPS) check("upd_value", 32'(update_value), 32'(words[exp_i]));
                check("upd_axis", 32'(update_axis), 32'(v.axis));
                check("upd_bank", 32'(update_bank), 32'(v.bank));
                writes++;
                if (exp_i == v.abort_at) begin
                    reset_n = 1'b0;
                    #1;
                    check("abort_update_en", 32'(update_en), 32'd0);
                    check("abort_busy",      32'(busy),      32'd0);
                    check("abort_done",      32'(done),      32'd0);
                    repeat (2) begin
                        @(negedge sys_clk);
                        #1;
                        check("abort_no_done", 32'(done), 32'd0);
                    end
                    @(negedge sys_clk);
                    reset_n = 1'b1;
                    return;
                end
                exp_i++;
            end else begin
                if (update_axis != 2'd0 || update_bank != 2'd0 ||
                    update_index != 4'd0 || update_value != 16'd0) zero_bad++;
                if (writes > 0 && !done) gaps++;
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_id", 32'(done_id), 32'(v.req));
                check("error",   32'(error),   32'(exp_err));
                check("writes",  32'(writes),  32'(exp_err ? 0 : NUM_TAPS));
                check("stall_gaps", 32'(gaps), 32'(exp_gaps));
                check("update_zero_when_idle", 32'(zero_bad), 32'd0);
                check("update_during_collect", 32'(upd_in_collect), 32'd0);
                if (v.chk_lat) check("latency", 32'(lat), 32'(NW + NUM_TAPS + 2));
            end
        end
        if (!seen_done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        @(negedge sys_clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    load_vec_t vecs [6];

    initial begin
        vecs[0] = mk(0, 0, AXIS_X,    2'd2, 16'h0100, 16'h0001, -1, 0, 0, -1, 1);
        vecs[1] = mk(1, 0, AXIS_Y,    2'd1, 16'hA000, 16'h0111,  7, 5, 0, -1, 0);
        vecs[2] = mk(0, 0, AXIS_NONE, 2'd3, 16'h5555, 16'h0003, -1, 0, 0, -1, 0);
        vecs[3] = mk(1, 0, AXIS_Z,    2'd0, 16'hFFF0, 16'h1234,  0, 2, 0, -1, 0);
        vecs[4] = mk(0, 0, AXIS_X,    2'd1, 16'h1000, 16'h0000, -1, 0, 0, -1, 1);
        vecs[5] = mk(1, 0, AXIS_Y,    2'd2, 16'h1000, 16'h0000, -1, 0, 1, -1, 0);

        reset_n = 1'b0; available = 1'b1;
        r0_cmd_valid = 1'b0; r0_axis = 2'd0; r0_bank = 2'd0;
        r0_data_valid = 1'b0; r0_data = 16'd0;
        r1_cmd_valid = 1'b0; r1_axis = 2'd0; r1_bank = 2'd0;
        r1_data_valid = 1'b0; r1_data = 16'd0;
        repeat (2) @(negedge sys_clk);
        #1;
        check("reset_busy",      32'(busy),          32'd0);
        check("reset_done",      32'(done),          32'd0);
        check("reset_error",     32'(error),         32'd0);
        check("reset_update_en", 32'(update_en),     32'd0);
        check("reset_cmd_ready", 32'(r0_cmd_ready),  32'd0);
        check("reset_data_rdy",  32'(r0_data_ready), 32'd0);
        @(negedge sys_clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_load(vecs[i]);

        // simultaneous requests after a fresh reset alternate 0,1,0,1
        @(negedge sys_clk); reset_n = 1'b0;
        @(negedge sys_clk); reset_n = 1'b1;
        for (int r = 0; r < 4; r++)
            run_load(mk(r % 2, 1, 2'(1 + r % 3), 2'(r), 16'(16'h0200 * (r + 1)),
                        16'h0005, -1, 0, 0, -1, 0));

        // reset during commit at index 4, then a clean load from index 0
        run_load(mk(0, 0, AXIS_X, 2'd1, 16'h2000, 16'h0001, -1, 0, 0, 4, 0));
        run_load(mk(0, 0, AXIS_Y, 2'd3, 16'h3000, 16'h0007, -1, 0, 0, -1, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 16, coefficients per bank load.
REQ-002 SHALL have port sys_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports rN_cmd_valid/rN_cmd_ready (N=0,1)  in/out  1/1  per-requester bank-load command handshake.
REQ-005 SHALL have ports rN_axis/rN_bank  in  2/2  command target axis (1=x, 2=y, 3=z) and bank, sampled at command handshake.
REQ-006 SHALL have ports rN_data_valid/rN_data_ready/rN_data  in/out/in  1/1/16  per-requester coefficient word stream.
REQ-007 SHALL have port available  in  1  signal-path idle flag; 1 = no filter cycle in progress.
REQ-008 SHALL have ports update_en/update_axis/update_bank/update_index/update_value  out  1/2/2/4/16  coefficient write port to signal path.
REQ-009 SHALL have ports busy/done/done_id/error  out  1/1/1/1  load in progress, one-cycle completion pulse, requester served, load rejected (valid with done).

Function
REQ-010 SHALL implement states IDLE, COLLECT, WAIT_IDLE, COMMIT, DONE.
REQ-011 IDLE: rN_cmd_ready SHALL be 1 only for the arbiter-granted requester; handshake (valid&ready) latches axis, bank, grant id, resets word count, -> COLLECT.
REQ-012 Arbitration SHALL be round-robin over requesters with valid commands; sole requester always granted; after reset requester 0 wins a tie.
REQ-013 COLLECT: rN_data_ready SHALL be 1 only for the granted requester; each data handshake stores word at shadow[count], count increments; ungranted data_ready stays 0.
REQ-014 After NUM_TAPS words (plus checksum word, REQ-024) SHALL go to WAIT_IDLE, or to DONE with error=1 if latched axis==0 or checksum fails.
REQ-015 WAIT_IDLE: SHALL go to COMMIT on first cycle available==1.
REQ-016 COMMIT: each cycle with available==1 SHALL assert update_en with update_index=i, update_value=shadow[i], latched axis/bank, i incrementing 0..NUM_TAPS-1.
REQ-017 COMMIT with available==0 SHALL deassert update_en and hold i (pause, no skip, no repeat).
REQ-018 After the write of index NUM_TAPS-1 SHALL enter DONE; minimum command-complete latency = data words + 1 (WAIT_IDLE) + 16 + 1.
REQ-019 DONE: done=1 for exactly one cycle, done_id=grant id, error as determined; -> IDLE next cycle.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Shadow writes SHALL not touch update_* outputs; a failed/rejected load SHALL produce zero update_en cycles.
REQ-022 update_axis/update_bank/update_index/update_value SHALL be 0 whenever update_en==0.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, all outputs 0 (except per REQ-011 ready logic in IDLE), count/i 0, arbiter priority to requester 0; a partly collected or partly committed load is abandoned without done; shadow contents need not clear.

Configuration
REQ-024 With COEFF_CHECKSUM_EN defined: COLLECT SHALL accept one extra word after the NUM_TAPS coefficients; it must equal the 16-bit wrap-around sum of the coefficients, else DONE with error=1.
REQ-025 Without COEFF_CHECKSUM_EN: exactly NUM_TAPS words are collected, no checksum logic exists, error only from axis==0.

Structure
REQ-026 Package coeff_loader_pkg SHALL hold the state enum, NUM_TAPS default, axis encoding constants (AXIS_NONE/X/Y/Z).
REQ-027 Sub-module rr_arbiter_2 SHALL implement the 2-way round-robin grant with priority update on command handshake.

Verification
REQ-028 r0 cmd axis=1 bank=2, words 0x0100..0x010F, available=1 -> 16 consecutive update_en cycles index 0..15 matching values, then done=1, done_id=0, error=0.
REQ-029 r0 and r1 cmd_valid same cycle after reset -> r0 served first, r1 second; repeated simultaneous requests alternate 0,1,0,1.
REQ-030 available forced 0 for 5 cycles at index 7 of COMMIT -> update_en low 5 cycles, resumes at index 7, total 16 writes.
REQ-031 cmd axis=0 -> all words consumed, no update_en, done=1 with error=1.
REQ-032 COEFF_CHECKSUM_EN, 16 words of 0x1000 with checksum 0x0000 -> commit; checksum 0x0001 -> no writes, error=1.
REQ-033 reset_n asserted at COMMIT index 4 -> update_en 0 at once, no done, next command loads normally from index 0.
